// File: rtl/mc_isa_pkg.sv
// ISA constants, control-word layout and the instruction decode function
// shared by the 4-bit microcontroller instruction decoder.
package mc_isa_pkg;

  localparam int unsigned IR_W   = 8;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned SEL_W  = 4;
  localparam int unsigned EN_W   = 9;
  localparam int unsigned CODE_W = 3;

  // Opcode prefixes, matched against the top bits of ir
  localparam logic [0:0] OP_LDI = 1'b0;
  localparam logic [1:0] OP_MOV = 2'b10;
  localparam logic [2:0] OP_ALU = 3'b110;
  localparam logic [3:0] OP_JMP = 4'b1110;
  localparam logic [3:0] OP_JNZ = 4'b1111;

  localparam logic [SEL_W-1:0] SRC_X0    = 4'd0;
  localparam logic [SEL_W-1:0] SRC_X1    = 4'd1;
  localparam logic [SEL_W-1:0] SRC_Y0    = 4'd2;
  localparam logic [SEL_W-1:0] SRC_Y1    = 4'd3;
  localparam logic [SEL_W-1:0] SRC_R     = 4'd4;
  localparam logic [SEL_W-1:0] SRC_M     = 4'd5;
  localparam logic [SEL_W-1:0] SRC_I     = 4'd6;
  localparam logic [SEL_W-1:0] SRC_DM    = 4'd7;
  localparam logic [SEL_W-1:0] SRC_IMM   = 4'd8;
  localparam logic [SEL_W-1:0] SRC_IPINS = 4'd9;

  localparam int unsigned EN_X0 = 0;
  localparam int unsigned EN_X1 = 1;
  localparam int unsigned EN_Y0 = 2;
  localparam int unsigned EN_Y1 = 3;
  localparam int unsigned EN_R  = 4;
  localparam int unsigned EN_M  = 5;
  localparam int unsigned EN_I  = 6;
  localparam int unsigned EN_DM = 7;
  localparam int unsigned EN_O  = 8;

  localparam logic [CODE_W-1:0] CODE_X0 = 3'd0;
  localparam logic [CODE_W-1:0] CODE_X1 = 3'd1;
  localparam logic [CODE_W-1:0] CODE_Y0 = 3'd2;
  localparam logic [CODE_W-1:0] CODE_Y1 = 3'd3;
  localparam logic [CODE_W-1:0] CODE_O  = 3'd4;
  localparam logic [CODE_W-1:0] CODE_M  = 3'd5;
  localparam logic [CODE_W-1:0] CODE_I  = 3'd6;
  localparam logic [CODE_W-1:0] CODE_DM = 3'd7;

  typedef enum logic {FETCH, EXEC} state_e;

  typedef struct packed {
    logic [EN_W-1:0]  reg_en;
    logic [SEL_W-1:0] source_sel;
    logic             i_sel;
    logic             x_sel;
    logic             y_sel;
  } ctrl_t;

  // Destination code to its single register-enable bit
  function automatic logic [EN_W-1:0] dst_enable(input logic [CODE_W-1:0] dst);
    logic [EN_W-1:0] en;
    en = '0;
    unique case (dst)
      CODE_X0: en[EN_X0] = 1'b1;
      CODE_X1: en[EN_X1] = 1'b1;
      CODE_Y0: en[EN_Y0] = 1'b1;
      CODE_Y1: en[EN_Y1] = 1'b1;
      CODE_O:  en[EN_O]  = 1'b1;
      CODE_M:  en[EN_M]  = 1'b1;
      CODE_I:  en[EN_I]  = 1'b1;
      CODE_DM: en[EN_DM] = 1'b1;
    endcase
    return en;
  endfunction

  // Full control word for one instruction; jumps produce an all-zero word
  function automatic ctrl_t decode(input logic [IR_W-1:0] ir);
    ctrl_t             c;
    logic [CODE_W-1:0] dst;
    logic [CODE_W-1:0] src;
    logic              touches_dm;
    c          = '0;
    dst        = ir[6:4];
    src        = ir[2:0];
    touches_dm = 1'b0;
    if (ir[7] == OP_LDI) begin
      dst          = ir[6:4];
      c.source_sel = SRC_IMM;
      c.reg_en     = dst_enable(dst);
      touches_dm   = (dst == CODE_DM);
    end else if (ir[7:6] == OP_MOV) begin
      dst          = ir[5:3];
      c.source_sel = (dst == src) ? SRC_IPINS : {1'b0, src};
      c.reg_en     = dst_enable(dst);
      touches_dm   = (dst == CODE_DM) || (src == CODE_DM);
    end else if (ir[7:5] == OP_ALU) begin
      c.reg_en[EN_R] = 1'b1;
      c.x_sel        = ir[4];
      c.y_sel        = ir[3];
    end
    // dm accesses post-increment i unless i itself is being written
    if (touches_dm && (dst != CODE_I)) begin
      c.reg_en[EN_I] = 1'b1;
      c.i_sel        = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/instruction_decoder_if.sv
// Program-memory and datapath-control bundle between the decoder (master)
// and the computational unit / program ROM (slave).
interface instruction_decoder_if #(parameter int unsigned PC_WIDTH = 8);
  import mc_isa_pkg::*;

  logic [PC_WIDTH-1:0] pm_address;
  logic [IR_W-1:0]     pm_data;
  logic                r_eq_0;
  logic [NIB_W-1:0]    ir_nibble;
  logic [SEL_W-1:0]    source_sel;
  logic [EN_W-1:0]     reg_en;
  logic                i_sel;
  logic                x_sel;
  logic                y_sel;

  modport master (
    output pm_address, ir_nibble, source_sel, reg_en, i_sel, x_sel, y_sel,
    input  pm_data, r_eq_0
  );

  modport slave (
    input  pm_address, ir_nibble, source_sel, reg_en, i_sel, x_sel, y_sel,
    output pm_data, r_eq_0
  );

endinterface

// File: rtl/program_counter.sv
// Program counter: increments modulo 2^PC_WIDTH or loads a new low nibble
// inside the current 16-word page.
module program_counter
  import mc_isa_pkg::*;
#(
  parameter int unsigned PC_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_i,
  input  logic                inc_en_i,
  input  logic                load_en_i,
  input  logic [NIB_W-1:0]    target_i,
  output logic [PC_WIDTH-1:0] pc_o
);

  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_en_i) begin
      pc_d = {pc_q[PC_WIDTH-1:NIB_W], target_i};
    end else if (inc_en_i) begin
      pc_d = pc_q + PC_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/instruction_decoder.sv
// Two-state fetch/execute sequencer: latches an instruction in FETCH and
// drives the datapath control word for exactly the following EXEC cycle.
module instruction_decoder
  import mc_isa_pkg::*;
#(
  parameter int unsigned PC_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  sync_reset,
  instruction_decoder_if.master bus
);

  state_e          state_q;
  logic [IR_W-1:0] ir_q;
  ctrl_t           ctrl_q;

  logic is_exec_c;
  logic jump_c;
  logic load_pc_c;
  logic inc_pc_c;

  // Control word is decoded from pm_data at fetch so it is registered for EXEC
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      state_q <= FETCH;
      ir_q    <= 8'h00;
      ctrl_q  <= '0;
    end else begin
      unique case (state_q)
        FETCH: begin
          ir_q    <= bus.pm_data;
          ctrl_q  <= decode(bus.pm_data);
          state_q <= EXEC;
        end
        EXEC: begin
          ctrl_q  <= '0;
          state_q <= FETCH;
        end
      endcase
    end
  end

  always_comb begin
    is_exec_c = (state_q == EXEC) && !sync_reset;
    jump_c    = (ir_q[7:4] == OP_JMP) || ((ir_q[7:4] == OP_JNZ) && !bus.r_eq_0);
    load_pc_c = is_exec_c && jump_c;
    inc_pc_c  = is_exec_c && !jump_c;
  end

  program_counter #(.PC_WIDTH(PC_WIDTH)) u_pc (
    .clk       (clk),
    .rst_i     (sync_reset),
    .inc_en_i  (inc_pc_c),
    .load_en_i (load_pc_c),
    .target_i  (ir_q[NIB_W-1:0]),
    .pc_o      (bus.pm_address)
  );

  // Reset blanks every control output in the same cycle it is asserted
  assign bus.reg_en     = sync_reset ? '0   : ctrl_q.reg_en;
  assign bus.source_sel = sync_reset ? '0   : ctrl_q.source_sel;
  assign bus.i_sel      = sync_reset ? 1'b0 : ctrl_q.i_sel;
  assign bus.x_sel      = sync_reset ? 1'b0 : ctrl_q.x_sel;
  assign bus.y_sel      = sync_reset ? 1'b0 : ctrl_q.y_sel;
  assign bus.ir_nibble  = sync_reset ? '0   : ir_q[NIB_W-1:0];

endmodule
